trap_unit: RTL and testbench
============================

# trap_unit

Parametrised machine-mode trap controller for the 5-stage RV32 core, evaluated against the instruction in MEM. Owns mstatus/mie/mip/mtvec/mepc/mcause/mtval. Arbitrates synchronous exceptions, mret and NUM_IRQ external interrupt lines, and issues pipeline flushes. Redirects fetch through a registered one-cycle redirect stage.

## Interface
- NUM_IRQ, 4: external interrupt lines (1..16); line i reports mcause 16+i and mip/mie bit 16+i.
- MTVEC_RST, 32'h0000_0000: mtvec reset value.
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset, asynchronous, active-high.
- irq  in  NUM_IRQ  level interrupt lines, asynchronous to clk.
- mem_valid  in  1  MEM holds a real (non-bubble) instruction.
- illegal_inst, ecall_m, l_access_fault, s_access_fault  in  1 each  exception flags of the MEM instruction.
- mret  in  1  MEM instruction is mret.
- epc_cur, epc_next  in  32  PC of the MEM instruction, and its successor.
- fault_addr  in  32  data address for load/store faults.
- csr_rw  in  1  MEM instruction is a CSR op.
- csr_wsc  in  2  01 write, 10 set, 11 clear (inst[13:12]).
- csr_addr  in  12  CSR address.
- csr_wdata  in  32  operand, rs1 or zero-extended zimm, already muxed.
- csr_rdata  out  32  combinational read of csr_addr; 0 for unimplemented addresses.
- flush_fd, flush_de, flush_em, flush_mw  out  1  stage-register flushes.
- regwrite_cancel  out  1  suppress WB write of the MEM instruction.
- redirect_valid  out  1  fetch must load pc_redirect.
- pc_redirect  out  32  redirect target, registered.

## Operation
- mip[16+i]: irq[i] through a 2-flop synchroniser. Software writes to mip are ignored.
- Implemented mie bits: 16..16+NUM_IRQ-1. All other mie/mip bits read 0.
- mstatus: only MIE (bit 3) and MPIE (bit 7) are implemented; all other bits read 0.
- Interrupt pending: mstatus.MIE & |(mip & mie). The lowest index wins.
- Exception priority: illegal (cause 2) > ecall_m (11) > load fault (5) > store fault (7).
- An exception is taken when mem_valid and any exception flag is set.
  - Writes mepc=epc_cur.
  - Writes mtval: fault_addr for causes 5 and 7, epc_cur for cause 2, 0 for cause 11.
- An interrupt is taken when mem_valid, it is pending, and the instruction has no exception and is not mret. Exceptions and mret always beat interrupts.
  - The MEM instruction completes.
  - Writes mepc=epc_next, mtval=0, mcause={1,cause}.
- On trap entry: MPIE<=MIE, MIE<=0.
- On mret: MIE<=MPIE, MPIE<=1.
- CSR write: applied at posedge when csr_rw & mem_valid and no trap is taken that cycle.
  - csr_wsc 01 replaces, 10 ORs, 11 clears with ~csr_wdata.
  - mepc[1:0] is hardwired 0.
- FSM:
  - IDLE -> REDIR on any trap or mret; latches the target.
  - REDIR -> IDLE unconditionally.
  - In REDIR, no trap, interrupt or mret is accepted. Flags presented in REDIR are ignored; the flushed stages guarantee they are bubbles.
- Target:
  - mret: mepc, using the value before the current cycle's writes.
  - Trap: mtvec.BASE (mtvec & ~3).

## Timing
- Cycle T (detect), combinational:
  - Exception: all four flushes and regwrite_cancel.
  - Interrupt: flush_fd, flush_de, flush_em only; MEM proceeds to WB.
  - mret: flush_fd, flush_de, flush_em.
- CSR side effects commit at the posedge that ends cycle T.
- Cycle T+1 (REDIR): redirect_valid=1, flush_fd=1, pc_redirect valid.
- Trap-to-fetch latency is 2 cycles.
- irq to mip latency: 2 cycles.
- Back-to-back: a trap is accepted in T+2 at the earliest.
- Reset values:
  - Outputs: all flushes, regwrite_cancel and redirect_valid 0; pc_redirect 0.
  - State: FSM=IDLE; mstatus=0, mie=0, mepc=0, mcause=0, mtval=0; mtvec=MTVEC_RST; synchronisers 0.
- Reset asserted in REDIR aborts the redirect immediately.

## Configuration
- TRAP_VECTORED_EN defined:
  - mtvec[1:0] MODE is writable; 0 = direct, 1 = vectored. Values 2 and 3 are written as 0.
  - Vectored mode: interrupts target BASE+4*cause; exceptions target BASE.
- Undefined: mtvec[1:0] is hardwired 0; every trap targets BASE.

## Test plan
- Illegal at epc_cur=0x100, mtvec=0x200:
  - T: all flushes and regwrite_cancel.
  - T+1: redirect_valid, pc_redirect=0x200.
  - mcause=2, mepc=0x100, mtval=0x100.
- Load fault and ecall_m together, fault_addr=0x8000_0004: mcause=11, mtval=0.
- Load fault alone, same fault_addr: mcause=5, mtval=0x8000_0004.
- irq=4'b0110, mie bits 17 and 18 set, MIE=1, epc_next=0x44; TRAP_VECTORED_EN with mtvec=0x201:
  - mcause=0x8000_0011, mepc=0x44.
  - pc_redirect=0x244.
  - MIE=0, MPIE=1.
  - regwrite_cancel=0.
- mret with mepc=0x44, MPIE=1 -> T+1 pc_redirect=0x44, then MIE=1.
- Trap in REDIR cycle ignored; csrrs mie,0x10000 with a concurrent illegal flag -> mie unchanged.
- Async rst pulse during REDIR -> redirect_valid drops in the same cycle; mtvec=MTVEC_RST.

Source files
------------

// File: rtl/trap_unit_if.sv
// -----------------------------------------------------------------------------
// trap_unit_if
// Bundles the MEM-stage trap/CSR request signals and the flush/redirect
// responses of trap_unit.
//   master : pipeline side (drives irq, MEM flags, CSR request; reads results)
//   slave  : trap_unit side
// Parameter NUM_IRQ must match the trap_unit instance it connects to.
// -----------------------------------------------------------------------------
interface trap_unit_if #(
   parameter int NUM_IRQ = 4
);
   logic [NUM_IRQ-1:0] irq;
   logic               mem_valid;
   logic               illegal_inst;
   logic               ecall_m;
   logic               l_access_fault;
   logic               s_access_fault;
   logic               mret;
   logic [31:0]        epc_cur;
   logic [31:0]        epc_next;
   logic [31:0]        fault_addr;
   logic               csr_rw;
   logic [1:0]         csr_wsc;
   logic [11:0]        csr_addr;
   logic [31:0]        csr_wdata;
   logic [31:0]        csr_rdata;
   logic               flush_fd;
   logic               flush_de;
   logic               flush_em;
   logic               flush_mw;
   logic               regwrite_cancel;
   logic               redirect_valid;
   logic [31:0]        pc_redirect;

   modport master (
      output irq, mem_valid, illegal_inst, ecall_m, l_access_fault, s_access_fault,
             mret, epc_cur, epc_next, fault_addr, csr_rw, csr_wsc, csr_addr, csr_wdata,
      input  csr_rdata, flush_fd, flush_de, flush_em, flush_mw, regwrite_cancel,
             redirect_valid, pc_redirect
   );

   modport slave (
      input  irq, mem_valid, illegal_inst, ecall_m, l_access_fault, s_access_fault,
             mret, epc_cur, epc_next, fault_addr, csr_rw, csr_wsc, csr_addr, csr_wdata,
      output csr_rdata, flush_fd, flush_de, flush_em, flush_mw, regwrite_cancel,
             redirect_valid, pc_redirect
   );
endinterface

// File: rtl/trap_unit.sv
// -----------------------------------------------------------------------------
// trap_unit
// Machine-mode trap controller for the 5-stage RV32 core. Evaluates the MEM
// instruction, owns mstatus/mie/mip/mtvec/mepc/mcause/mtval, arbitrates
// exceptions, mret and NUM_IRQ external interrupts, issues stage flushes and
// redirects fetch through a registered one-cycle REDIR state.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset
//   bus  : trap_unit_if.slave (irq, MEM exception flags, mret, epc_cur/next,
//          fault_addr, CSR request/read data, flushes, regwrite_cancel,
//          redirect_valid, pc_redirect)
// Configuration macro: TRAP_VECTORED_EN
//   defined   : mtvec MODE writable (1 = vectored, 2/3 stored as 0);
//               vectored interrupts target BASE + 4*cause
//   undefined : mtvec MODE hardwired 0, every trap targets BASE
// -----------------------------------------------------------------------------
module trap_unit #(
   parameter int          NUM_IRQ   = 4,
   parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
   input logic        clk,
   input logic        rst,
   trap_unit_if.slave bus
);

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;
   localparam logic [11:0] CSR_MIP     = 12'h344;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_REDIR = 1'b1;

   logic [0:0]         r_state;
   logic               r_mstatus_mie;
   logic               r_mstatus_mpie;
   logic [NUM_IRQ-1:0] r_mie;
   logic [NUM_IRQ-1:0] r_irq_meta;
   logic [NUM_IRQ-1:0] r_mip;
   logic [31:2]        r_mtvec_base;
   logic [31:2]        r_mepc;
   logic [31:0]        r_mcause;
   logic [31:0]        r_mtval;
   logic [31:0]        r_pc_redirect;

   logic               w_mtvec_mode;
   logic               w_idle;
   logic               w_exc_any;
   logic               w_exc_take;
   logic               w_mret_take;
   logic [NUM_IRQ-1:0] w_irq_masked;
   logic               w_irq_take;
   logic               w_trap_take;
   logic [4:0]         w_irq_idx;
   logic [4:0]         w_irq_cause;
   logic [4:0]         w_exc_cause;
   logic [31:0]        w_exc_tval;
   logic [31:0]        w_target;
   logic [31:0]        w_mie_word;
   logic [31:0]        w_mip_word;
   logic [31:0]        w_csr_rdata;
   logic [31:0]        w_csr_new;
   logic               w_csr_we;
   logic               w_unused_bits;

`ifdef TRAP_VECTORED_EN
   logic r_mtvec_mode;
   assign w_mtvec_mode = r_mtvec_mode;
`else
   assign w_mtvec_mode = 1'b0;
`endif

   // epc_next[1:0] never reaches state because mepc is word aligned
   assign w_unused_bits = ^bus.epc_next[1:0];

   assign w_idle       = (r_state == S_IDLE);
   assign w_exc_any    = bus.illegal_inst | bus.ecall_m | bus.l_access_fault | bus.s_access_fault;
   assign w_exc_take   = w_idle & bus.mem_valid & w_exc_any;
   // an mret that also carries an exception flag is handled as the exception
   assign w_mret_take  = w_idle & bus.mem_valid & bus.mret & ~w_exc_any;
   assign w_irq_masked = r_mip & r_mie;
   assign w_irq_take   = w_idle & bus.mem_valid & r_mstatus_mie & (|w_irq_masked)
                         & ~w_exc_any & ~bus.mret;
   assign w_trap_take  = w_exc_take | w_irq_take;
   assign w_irq_cause  = 5'd16 + w_irq_idx;

   // Lowest-index pending interrupt line wins
   always_comb begin
      w_irq_idx = 5'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (w_irq_masked[i]) begin
            w_irq_idx = 5'(i);
         end else begin
            w_irq_idx = w_irq_idx;
         end
      end
   end

   // Exception cause and mtval by fixed priority illegal > ecall > load > store
   always_comb begin
      w_exc_cause = 5'd7;
      w_exc_tval  = bus.fault_addr;
      if (bus.illegal_inst) begin
         w_exc_cause = 5'd2;
         w_exc_tval  = bus.epc_cur;
      end else if (bus.ecall_m) begin
         w_exc_cause = 5'd11;
         w_exc_tval  = 32'd0;
      end else if (bus.l_access_fault) begin
         w_exc_cause = 5'd5;
         w_exc_tval  = bus.fault_addr;
      end else begin
         w_exc_cause = 5'd7;
         w_exc_tval  = bus.fault_addr;
      end
   end

   // Redirect target; mret uses mepc as it stood before this cycle's writes
   always_comb begin
      w_target = {r_mtvec_base, 2'b00};
      if (w_mret_take) begin
         w_target = {r_mepc, 2'b00};
      end else if (w_irq_take && w_mtvec_mode) begin
         w_target = {r_mtvec_base, 2'b00} + {25'd0, w_irq_cause, 2'b00};
      end else begin
         w_target = {r_mtvec_base, 2'b00};
      end
   end

   // Combinational CSR read port; unimplemented addresses read 0
   always_comb begin
      w_mie_word                 = 32'd0;
      w_mip_word                 = 32'd0;
      w_mie_word[16 +: NUM_IRQ]  = r_mie;
      w_mip_word[16 +: NUM_IRQ]  = r_mip;
      w_csr_rdata                = 32'd0;
      case (bus.csr_addr)
         CSR_MSTATUS: w_csr_rdata = {24'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
         CSR_MIE:     w_csr_rdata = w_mie_word;
         CSR_MTVEC:   w_csr_rdata = {r_mtvec_base, 1'b0, w_mtvec_mode};
         CSR_MEPC:    w_csr_rdata = {r_mepc, 2'b00};
         CSR_MCAUSE:  w_csr_rdata = r_mcause;
         CSR_MTVAL:   w_csr_rdata = r_mtval;
         CSR_MIP:     w_csr_rdata = w_mip_word;
         default:     w_csr_rdata = 32'd0;
      endcase
   end

   // Read-modify-write value for csrrw / csrrs / csrrc
   always_comb begin
      w_csr_new = w_csr_rdata;
      case (bus.csr_wsc)
         2'b01:   w_csr_new = bus.csr_wdata;
         2'b10:   w_csr_new = w_csr_rdata | bus.csr_wdata;
         2'b11:   w_csr_new = w_csr_rdata & ~bus.csr_wdata;
         default: w_csr_new = w_csr_rdata;
      endcase
   end

   assign w_csr_we = w_idle & bus.mem_valid & bus.csr_rw & ~w_trap_take & (bus.csr_wsc != 2'b00);

   // Two-flop synchroniser feeding mip
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq_meta <= '0;
         r_mip      <= '0;
      end else begin
         r_irq_meta <= bus.irq;
         r_mip      <= r_irq_meta;
      end
   end

   // CSR state: software writes, trap entry and mret updates
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mie          <= '0;
         r_mtvec_base   <= MTVEC_RST[31:2];
`ifdef TRAP_VECTORED_EN
         r_mtvec_mode   <= (MTVEC_RST[1:0] == 2'b01);
`endif
         r_mepc         <= 30'd0;
         r_mcause       <= 32'd0;
         r_mtval        <= 32'd0;
      end else begin
         if (w_csr_we) begin
            case (bus.csr_addr)
               CSR_MSTATUS: begin
                  r_mstatus_mie  <= w_csr_new[3];
                  r_mstatus_mpie <= w_csr_new[7];
               end
               CSR_MIE:    r_mie <= w_csr_new[16 +: NUM_IRQ];
               CSR_MTVEC: begin
                  r_mtvec_base <= w_csr_new[31:2];
`ifdef TRAP_VECTORED_EN
                  r_mtvec_mode <= (w_csr_new[1:0] == 2'b01);
`endif
               end
               CSR_MEPC:   r_mepc   <= w_csr_new[31:2];
               CSR_MCAUSE: r_mcause <= w_csr_new;
               CSR_MTVAL:  r_mtval  <= w_csr_new;
               default:    r_mcause <= r_mcause;
            endcase
         end
         // trap blocks the CSR write; mret status update overrides a same-cycle write
         if (w_exc_take) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
            r_mepc         <= bus.epc_cur[31:2];
            r_mcause       <= {27'd0, w_exc_cause};
            r_mtval        <= w_exc_tval;
         end else if (w_irq_take) begin
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
            r_mepc         <= bus.epc_next[31:2];
            r_mcause       <= {1'b1, 26'd0, w_irq_cause};
            r_mtval        <= 32'd0;
         end else if (w_mret_take) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
         end
      end
   end

   // Redirect FSM: one REDIR cycle after every accepted trap or mret
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_pc_redirect <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_trap_take || w_mret_take) begin
                  r_state       <= S_REDIR;
                  r_pc_redirect <= w_target;
               end
            end
            S_REDIR: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.csr_rdata       = w_csr_rdata;
   assign bus.redirect_valid  = (r_state == S_REDIR);
   assign bus.pc_redirect     = r_pc_redirect;
   assign bus.flush_fd        = w_trap_take | w_mret_take | (r_state == S_REDIR);
   assign bus.flush_de        = w_trap_take | w_mret_take;
   assign bus.flush_em        = w_trap_take | w_mret_take;
   // an interrupted instruction still retires, so only exceptions kill MEM->WB
   assign bus.flush_mw        = w_exc_take;
   assign bus.regwrite_cancel = w_exc_take;

endmodule

// File: tb/tb_trap_unit.sv
// -----------------------------------------------------------------------------
// tb_trap_unit
// Directed and randomized stimulus for trap_unit, compared each cycle against
// a behavioural model of the machine-mode trap rules.
// -----------------------------------------------------------------------------
module tb_trap_unit;
   localparam int          NUM_IRQ   = 4;
   localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
   localparam logic [11:0] A_MSTATUS = 12'h300;
   localparam logic [11:0] A_MIE     = 12'h304;
   localparam logic [11:0] A_MTVEC   = 12'h305;
   localparam logic [11:0] A_MEPC    = 12'h341;
   localparam logic [11:0] A_MCAUSE  = 12'h342;
   localparam logic [11:0] A_MTVAL   = 12'h343;
   localparam logic [11:0] A_MIP     = 12'h344;
   localparam logic [31:0] IRQ_MASK  = ((32'd1 << NUM_IRQ) - 32'd1) << 16;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   trap_unit_if #(.NUM_IRQ(NUM_IRQ)) bus ();
   trap_unit #(.NUM_IRQ(NUM_IRQ), .MTVEC_RST(MTVEC_RST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // behavioural model state
   logic [31:0]        m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_pc;
   logic               m_redir;
   logic [NUM_IRQ-1:0] m_irq_q[$];

   task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(string tag, logic obs, logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mtvec_legal(logic [31:0] v);
`ifdef TRAP_VECTORED_EN
      return (v & ~32'd3) | ((v[1:0] == 2'b01) ? 32'd1 : 32'd0);
`else
      return v & ~32'd3;
`endif
   endfunction

   function automatic logic [31:0] mip_word();
      logic [31:0] w;
      w = 32'd0;
      for (int i = 0; i < NUM_IRQ; i++) w[16 + i] = m_irq_q[0][i];
      return w;
   endfunction

   function automatic logic [31:0] mread(logic [11:0] a);
      case (a)
         A_MSTATUS: return m_mstatus;
         A_MIE:     return m_mie;
         A_MTVEC:   return m_mtvec;
         A_MEPC:    return m_mepc;
         A_MCAUSE:  return m_mcause;
         A_MTVAL:   return m_mtval;
         A_MIP:     return mip_word();
         default:   return 32'd0;
      endcase
   endfunction

   task automatic mwrite(logic [11:0] a, logic [31:0] v);
      case (a)
         A_MSTATUS: m_mstatus = v & 32'h0000_0088;
         A_MIE:     m_mie     = v & IRQ_MASK;
         A_MTVEC:   m_mtvec   = mtvec_legal(v);
         A_MEPC:    m_mepc    = v & ~32'd3;
         A_MCAUSE:  m_mcause  = v;
         A_MTVAL:   m_mtval   = v;
         default:   ;
      endcase
   endtask

   task automatic model_reset();
      m_mstatus = 32'd0; m_mie = 32'd0; m_mtvec = mtvec_legal(MTVEC_RST);
      m_mepc = 32'd0; m_mcause = 32'd0; m_mtval = 32'd0; m_pc = 32'd0;
      m_redir = 1'b0;
      m_irq_q = {};
      m_irq_q.push_back('0);
      m_irq_q.push_back('0);
   endtask

   task automatic set_idle();
      bus.mem_valid = 1'b0; bus.illegal_inst = 1'b0; bus.ecall_m = 1'b0;
      bus.l_access_fault = 1'b0; bus.s_access_fault = 1'b0; bus.mret = 1'b0;
      bus.csr_rw = 1'b0; bus.csr_wsc = 2'b00; bus.csr_addr = A_MSTATUS;
      bus.csr_wdata = 32'd0; bus.epc_cur = 32'd0; bus.epc_next = 32'd4;
      bus.fault_addr = 32'd0;
   endtask

   // one clock: predict, check outputs at negedge, advance model over posedge
   task automatic do_cycle();
      logic        any_exc, exc, mret_t, irq_t, trap;
      logic [31:0] pend, tgt, nv, old, code, old_mepc, old_mstatus;
      any_exc = bus.illegal_inst | bus.ecall_m | bus.l_access_fault | bus.s_access_fault;
      exc     = bus.mem_valid && !m_redir && any_exc;
      mret_t  = bus.mem_valid && !m_redir && bus.mret && !any_exc;
      pend    = mip_word() & m_mie;
      irq_t   = bus.mem_valid && !m_redir && m_mstatus[3] && (pend != 32'd0) && !any_exc && !bus.mret;
      trap    = exc || irq_t;
      @(negedge clk);
      chk1("flush_fd", bus.flush_fd, trap || mret_t || m_redir);
      chk1("flush_de", bus.flush_de, trap || mret_t);
      chk1("flush_em", bus.flush_em, trap || mret_t);
      chk1("flush_mw", bus.flush_mw, exc);
      chk1("regwrite_cancel", bus.regwrite_cancel, exc);
      chk1("redirect_valid", bus.redirect_valid, m_redir);
      chk32("pc_redirect", bus.pc_redirect, m_pc);
      chk32("csr_rdata", bus.csr_rdata, mread(bus.csr_addr));
      old_mepc    = m_mepc;
      old_mstatus = m_mstatus;
      tgt         = m_mtvec & ~32'd3;
      if (bus.mem_valid && bus.csr_rw && !m_redir && !trap && bus.csr_wsc != 2'b00) begin
         old = mread(bus.csr_addr);
         if (bus.csr_wsc == 2'b01)      nv = bus.csr_wdata;
         else if (bus.csr_wsc == 2'b10) nv = old | bus.csr_wdata;
         else                           nv = old & ~bus.csr_wdata;
         mwrite(bus.csr_addr, nv);
      end
      if (exc) begin
         code = bus.illegal_inst ? 32'd2 : bus.ecall_m ? 32'd11 : bus.l_access_fault ? 32'd5 : 32'd7;
         m_mcause  = code;
         m_mepc    = bus.epc_cur & ~32'd3;
         m_mtval   = (code == 32'd2) ? bus.epc_cur : (code == 32'd11) ? 32'd0 : bus.fault_addr;
         m_mstatus = old_mstatus[3] ? 32'h80 : 32'h0;
      end else if (irq_t) begin
         code = 32'd0;
         for (int i = NUM_IRQ - 1; i >= 0; i--) if (pend[16 + i]) code = 32'd16 + 32'(i);
         m_mcause  = 32'h8000_0000 | code;
         m_mepc    = bus.epc_next & ~32'd3;
         m_mtval   = 32'd0;
         m_mstatus = old_mstatus[3] ? 32'h80 : 32'h0;
         if (m_mtvec[0]) tgt = tgt + 32'd4 * code;
      end else if (mret_t) begin
         tgt       = old_mepc;
         m_mstatus = 32'h80 | (old_mstatus[7] ? 32'h8 : 32'h0);
      end
      if (!m_redir && (trap || mret_t)) begin
         m_redir = 1'b1;
         m_pc    = tgt;
      end else begin
         m_redir = 1'b0;
      end
      @(posedge clk);
      #1;
      m_irq_q.push_back(bus.irq);
      void'(m_irq_q.pop_front());
   endtask

   task automatic csr_op(logic [11:0] a, logic [1:0] wsc, logic [31:0] d);
      set_idle();
      bus.mem_valid = 1'b1; bus.csr_rw = 1'b1; bus.csr_wsc = wsc;
      bus.csr_addr = a; bus.csr_wdata = d;
      do_cycle();
   endtask

   task automatic peek_lit(string tag, logic [11:0] a, logic [31:0] lit);
      set_idle();
      bus.csr_addr = a;
      do_cycle();
      chk32(tag, bus.csr_rdata, lit);
   endtask

   task automatic exc_cycle(logic ill, logic ec, logic lf, logic sf, logic [31:0] pc, logic [31:0] fa);
      set_idle();
      bus.mem_valid = 1'b1; bus.illegal_inst = ill; bus.ecall_m = ec;
      bus.l_access_fault = lf; bus.s_access_fault = sf;
      bus.epc_cur = pc; bus.epc_next = pc + 32'd4; bus.fault_addr = fa;
      do_cycle();
   endtask

   logic [11:0] addrs [8] = '{A_MSTATUS, A_MIE, A_MTVEC, A_MEPC, A_MCAUSE, A_MTVAL, A_MIP, 12'h7C0};

   initial begin
      rst = 1'b1;
      bus.irq = '0;
      set_idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state
      peek_lit("rst_mtvec", A_MTVEC, MTVEC_RST);
      peek_lit("rst_mstatus", A_MSTATUS, 32'd0);

      // illegal at 0x100 with mtvec 0x200
      csr_op(A_MTVEC, 2'b01, 32'h0000_0200);
      exc_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0);
      chk1("ill_redirect_valid", bus.redirect_valid, 1'b1);
      chk32("ill_pc_redirect", bus.pc_redirect, 32'h0000_0200);
      set_idle();
      do_cycle();
      peek_lit("ill_mcause", A_MCAUSE, 32'd2);
      peek_lit("ill_mepc", A_MEPC, 32'h0000_0100);
      peek_lit("ill_mtval", A_MTVAL, 32'h0000_0100);

      // ecall beats load fault
      exc_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0120, 32'h8000_0004);
      set_idle();
      do_cycle();
      peek_lit("ecall_mcause", A_MCAUSE, 32'd11);
      peek_lit("ecall_mtval", A_MTVAL, 32'd0);

      // load fault alone
      exc_cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0124, 32'h8000_0004);
      set_idle();
      do_cycle();
      peek_lit("lf_mcause", A_MCAUSE, 32'd5);
      peek_lit("lf_mtval", A_MTVAL, 32'h8000_0004);

      // external interrupt: lines 1 and 2 pending, line 1 wins
      bus.irq = 4'b0110;
      csr_op(A_MIE, 2'b01, 32'h0006_0000);
      csr_op(A_MTVEC, 2'b01, 32'h0000_0201);
      csr_op(A_MSTATUS, 2'b01, 32'h0000_0008);
      set_idle();
      bus.mem_valid = 1'b1; bus.epc_cur = 32'h40; bus.epc_next = 32'h44;
      do_cycle();
`ifdef TRAP_VECTORED_EN
      chk32("irq_pc_redirect", bus.pc_redirect, 32'h0000_0244);
`else
      chk32("irq_pc_redirect", bus.pc_redirect, 32'h0000_0200);
`endif
      bus.irq = '0;
      set_idle();
      do_cycle();
      peek_lit("irq_mcause", A_MCAUSE, 32'h8000_0011);
      peek_lit("irq_mepc", A_MEPC, 32'h0000_0044);
      peek_lit("irq_mstatus", A_MSTATUS, 32'h0000_0080);

      // mret back to 0x44
      set_idle();
      bus.mem_valid = 1'b1; bus.mret = 1'b1;
      do_cycle();
      chk32("mret_pc_redirect", bus.pc_redirect, 32'h0000_0044);
      set_idle();
      do_cycle();
      peek_lit("mret_mstatus", A_MSTATUS, 32'h0000_0088);

      // flags in REDIR ignored, and a trap blocks a concurrent CSR write
      exc_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0);
      set_idle();
      bus.mem_valid = 1'b1; bus.illegal_inst = 1'b1;
      bus.csr_rw = 1'b1; bus.csr_wsc = 2'b10; bus.csr_addr = A_MIE; bus.csr_wdata = 32'h0001_0000;
      do_cycle();
      peek_lit("redir_mie", A_MIE, 32'h0006_0000);
      set_idle();
      bus.mem_valid = 1'b1; bus.illegal_inst = 1'b1; bus.epc_cur = 32'h0000_0310;
      bus.csr_rw = 1'b1; bus.csr_wsc = 2'b10; bus.csr_addr = A_MIE; bus.csr_wdata = 32'h0001_0000;
      do_cycle();
      set_idle();
      do_cycle();
      peek_lit("trap_blocks_mie", A_MIE, 32'h0006_0000);

      // async reset during REDIR
      exc_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'h0);
      set_idle();
      #2;
      rst = 1'b1;
      #1;
      chk1("rst_redirect_valid", bus.redirect_valid, 1'b0);
      chk1("rst_flush_fd", bus.flush_fd, 1'b0);
      rst = 1'b0;
      model_reset();
      do_cycle();
      peek_lit("rst2_mtvec", A_MTVEC, MTVEC_RST);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         int r;
         set_idle();
         if ($urandom_range(0, 7) == 0) bus.irq = NUM_IRQ'($urandom);
         bus.mem_valid = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 15);
         bus.illegal_inst   = (r == 0) || (r == 10);
         bus.ecall_m        = (r == 1);
         bus.l_access_fault = (r == 2) || (r == 10);
         bus.s_access_fault = (r == 3) || (r == 11);
         bus.mret           = (r == 4) || (r == 11);
         bus.csr_rw         = (r >= 5) && (r <= 9);
         bus.csr_wsc        = 2'($urandom_range(0, 3));
         bus.csr_addr       = addrs[$urandom_range(0, 7)];
         bus.csr_wdata      = $urandom;
         bus.epc_cur        = $urandom & ~32'd3;
         bus.epc_next       = bus.epc_cur + 32'd4;
         bus.fault_addr     = $urandom;
         do_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
